writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 134 +++++++++++++
 tb/tb_writeback_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: registers the non-load result or the aligned load data into the
// register-file write port, with a same-cycle bypass. `RETIRE_COUNTER_EN adds the 64-bit instret counter.
module writeback_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic        in_is_load,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_low,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rd_address,
    output logic [31:0] rd_data,
    output logic        byp_valid,
    output logic [4:0]  byp_address,
    output logic [31:0] byp_data,
    output logic        retired
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [63:0] instret
`endif
);

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_lane_q, ld_lane_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        retired_q, retired_d;

    function automatic logic [31:0] align_load(input logic [2:0]  funct3,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  align_load = {{24{b[7]}}, b};
            3'b001:  align_load = {{16{h[15]}}, h};
            3'b100:  align_load = {24'd0, b};
            3'b101:  align_load = {16'd0, h};
            default: align_load = word;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        ld_rd_d     = ld_rd_q;
        ld_funct3_d = ld_funct3_q;
        ld_lane_d   = ld_lane_q;
        rd_addr_d   = 5'd0;
        rd_data_d   = 32'd0;
        retired_d   = 1'b0;
        in_ready    = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        ld_rd_d     = in_rd;
                        ld_funct3_d = in_funct3;
                        ld_lane_d   = in_addr_low;
                        state_d     = WAIT_LOAD;
                    end else begin
                        rd_addr_d = in_rd;
                        rd_data_d = (in_rd == 5'd0) ? 32'd0 : in_result;
                        retired_d = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    rd_addr_d = ld_rd_q;
                    rd_data_d = (ld_rd_q == 5'd0) ? 32'd0
                              : align_load(ld_funct3_q, ld_lane_q, dmem_rdata);
                    retired_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            retired_q <= retired_d;
        end
    end

    // Pending-load fields are only consumed in WAIT_LOAD, so they need no reset.
    always_ff @(posedge clk) begin
        ld_rd_q     <= ld_rd_d;
        ld_funct3_q <= ld_funct3_d;
        ld_lane_q   <= ld_lane_d;
    end

`ifdef RETIRE_COUNTER_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) instret_q <= 64'd0;
        else          instret_q <= instret_q + {63'd0, retired_d};
    end

    assign instret = instret_q;
`endif

    assign rd_address  = rd_addr_q;
    assign rd_data     = rd_data_q;
    assign retired     = retired_q;
    assign byp_address = rd_addr_q;
    assign byp_data    = rd_data_q;
    assign byp_valid   = (rd_addr_q != 5'd0);

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage against a transaction-level model, plus
// directed load-alignment / reset-abandon cases with literal expectations.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_is_load = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_low = '0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic [4:0]  rd_address;
    logic [31:0] rd_data;
    logic        byp_valid;
    logic [4:0]  byp_address;
    logic [31:0] byp_data;
    logic        retired;
`ifdef RETIRE_COUNTER_EN
    logic [63:0] instret;
`endif

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_result(in_result), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_addr_low(in_addr_low),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rd_address(rd_address), .rd_data(rd_data),
        .byp_valid(byp_valid), .byp_address(byp_address), .byp_data(byp_data),
        .retired(retired)
`ifdef RETIRE_COUNTER_EN
        , .instret(instret)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: one outstanding load at most; expected register-port contents after each edge.
    bit          m_busy = 1'b0;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lane;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic        e_ret = 1'b0;
    logic [63:0] e_instret = '0;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((w >> (8 * int'(lane))) & 32'hFF);
        h = 16'((w >> (lane[1] ? 16 : 0)) & 32'hFFFF);
        case (f3)
            3'd0:    return int'($signed(b));
            3'd1:    return int'($signed(h));
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("rd_address", 64'(rd_address), 64'(e_addr));
        chk("rd_data", 64'(rd_data), 64'(e_data));
        chk("byp_valid", 64'(byp_valid), 64'(e_addr != 0));
        chk("byp_address", 64'(byp_address), 64'(e_addr));
        chk("byp_data", 64'(byp_data), 64'(e_data));
        chk("retired", 64'(retired), 64'(e_ret));
        chk("in_ready", 64'(in_ready), 64'(!m_busy));
`ifdef RETIRE_COUNTER_EN
        chk("instret", instret, e_instret);
`endif
    endtask

    // Called at a falling edge: check current outputs, drive the next inputs, predict the next edge.
    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] res,
                        input logic ld, input logic [2:0] f3, input logic [1:0] lane,
                        input logic rv, input logic [31:0] rdata);
        compare_all();
        in_valid = v; in_rd = rd; in_result = res; in_is_load = ld;
        in_funct3 = f3; in_addr_low = lane; dmem_rvalid = rv; dmem_rdata = rdata;
        e_addr = 0; e_data = 0; e_ret = 0;
        if (!m_busy) begin
            if (v && ld) begin
                m_busy = 1; m_rd = rd; m_f3 = f3; m_lane = lane;
            end else if (v) begin
                e_addr = rd; e_data = (rd == 0) ? 0 : res; e_ret = 1;
            end
        end else if (rv) begin
            e_addr = m_rd; e_data = (m_rd == 0) ? 0 : ref_load(m_f3, m_lane, rdata);
            e_ret = 1; m_busy = 0;
        end
        if (e_ret) e_instret = e_instret + 1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        in_valid = 0; dmem_rvalid = 0;
        reset_n = 0;
        #1;
        m_busy = 0; e_addr = 0; e_data = 0; e_ret = 0; e_instret = 0;
        compare_all();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        repeat (3) idle();
        chk("lit_reset_addr", 64'(rd_address), 0);
        chk("lit_reset_data", 64'(rd_data), 0);
        chk("lit_reset_ready", 64'(in_ready), 1);

        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("lit_alu_addr", 64'(rd_address), 5);
        chk("lit_alu_data", 64'(rd_data), 64'hDEADBEEF);
        chk("lit_alu_bypv", 64'(byp_valid), 1);
        chk("lit_alu_ret", 64'(retired), 1);
        idle();
        chk("lit_alu_clear", 64'(rd_address), 0);

        step(1, 7, 0, 1, 3'b000, 2'd3, 0, 0);
        chk("lit_lb_wait_ready", 64'(in_ready), 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 32'h80FF_1234);
        chk("lit_lb_addr", 64'(rd_address), 7);
        chk("lit_lb_data", 64'(rd_data), 64'hFFFF_FF80);

        step(1, 8, 0, 1, 3'b100, 2'd3, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 32'h80FF_1234);
        chk("lit_lbu_data", 64'(rd_data), 64'h0000_0080);

        step(1, 9, 0, 1, 3'b101, 2'd2, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 32'h80FF_1234);
        chk("lit_lhu_data", 64'(rd_data), 64'h0000_80FF);

        step(1, 0, 32'h1234, 0, 0, 0, 0, 0);
        chk("lit_x0_data", 64'(rd_data), 0);
        chk("lit_x0_bypv", 64'(byp_valid), 0);
        chk("lit_x0_ret", 64'(retired), 1);

        step(1, 12, 0, 1, 3'b010, 2'd0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        chk("lit_abandon_ret", 64'(retired), 0);
        chk("lit_abandon_addr", 64'(rd_address), 0);
        chk("lit_abandon_ready", 64'(in_ready), 1);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 2) != 0),
                     ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                     $urandom,
                     1'($urandom_range(0, 1)),
                     3'($urandom),
                     2'($urandom),
                     1'($urandom_range(0, 2) == 0),
                     $urandom);
            end
        end
        idle();

`ifdef RETIRE_COUNTER_EN
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 5'(i + 1), 32'(i), 0, 0, 0, 0, 0);
        idle();
        chk("lit_instret_10", instret, 64'd10);
        dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        e_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        step(1, 3, 32'h1, 0, 0, 0, 0, 0);
        chk("lit_instret_wrap", instret, 64'd0);
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
